// File: rtl/ef_icap32_pkg.sv
// Shared types for the ef_icap32 input-capture timer: cfg mode encodings,
// FSM states and the saturating counter helper.
package ef_icap32_pkg;

  typedef enum logic [1:0] {
    MODE_PERIOD = 2'b00,
    MODE_HIGH   = 2'b01,
    MODE_LOW    = 2'b10,
    MODE_BOTH   = 2'b11
  } cap_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ARM  = 2'b01,
    ST_MEAS = 2'b10
  } cap_state_t;

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/ef_icap32_edge.sv
// Synchronizes the asynchronous capture input and produces one-clk rise/fall
// pulses by comparing the synchronized value against a last-value flop.
module ef_icap32_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~last_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & last_q;

endmodule

// File: rtl/ef_icap32.sv
// Input-capture timer: measures period / high / low time of cap_in in
// prescaled ticks, with one-shot or continuous operation and a tick timeout.
module ef_icap32
  import ef_icap32_pkg::*;
#(
  parameter int PRW         = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            start,
  input  logic [PRW-1:0]  prescaler,
  input  logic [2:0]      cfg,
  input  logic [31:0]     timeout,
  input  logic            cap_in,
  output logic [31:0]     cnt,
  output logic [31:0]     cap_period,
  output logic [31:0]     cap_high,
  output logic            cap_valid,
  output logic            timeout_flag,
  output logic            busy
);

  cap_state_t     state;
  cap_mode_t      mode;
  logic           continuous;
  logic           rise;
  logic           fall;
  logic           start_edge;
  logic           end_edge;
  logic [PRW-1:0] psc_cnt;
  logic           tick;
  logic [31:0]    cnt_inc;
  logic           timeout_hit;

  ef_icap32_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (cap_in),
    .rise (rise),
    .fall (fall)
  );

  assign mode       = cap_mode_t'(cfg[1:0]);
  assign continuous = cfg[2];
  assign start_edge = (mode == MODE_LOW)  ? fall : rise;
  assign end_edge   = (mode == MODE_HIGH) ? fall : rise;

  // Free-running prescaler; held at the reload value while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt <= '0;
    end else if (!en || (psc_cnt == '0)) begin
      psc_cnt <= prescaler;
    end else begin
      psc_cnt <= psc_cnt - PRW'(1);
    end
  end

  assign tick = en && (psc_cnt == '0);

  // Captured values include the tick landing on the capturing clock, so an
  // interval of N clocks at prescaler 0 reads back as N.
  assign cnt_inc     = sat_inc(cnt, tick);
  assign timeout_hit = (timeout != 32'd0) && tick && (cnt == timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cap_period   <= '0;
      cap_high     <= '0;
      cap_valid    <= 1'b0;
      timeout_flag <= 1'b0;
      busy         <= 1'b0;
    end else begin
      cap_valid    <= 1'b0;
      timeout_flag <= 1'b0;
      if (!en) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_ARM;
              busy  <= 1'b1;
            end
          end
          ST_ARM: begin
            if (start_edge) begin
              state <= ST_MEAS;
              cnt   <= '0;
            end
          end
          ST_MEAS: begin
            if (end_edge) begin
              cap_period <= cnt_inc;
              cap_valid  <= 1'b1;
              if (!continuous) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                cnt   <= cnt_inc;
              end else if ((mode == MODE_PERIOD) || (mode == MODE_BOTH)) begin
                cnt <= '0;
              end else begin
                state <= ST_ARM;
                cnt   <= cnt_inc;
              end
            end else if (timeout_hit) begin
              timeout_flag <= 1'b1;
              cnt          <= '0;
              if (continuous) begin
                state <= ST_ARM;
              end else begin
                state <= ST_IDLE;
                busy  <= 1'b0;
              end
            end else begin
              cnt <= cnt_inc;
              if ((mode == MODE_BOTH) && fall) begin
                cap_high <= cnt_inc;
              end
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ef_icap32.sv
// Scoreboard bench for ef_icap32: stimulus tasks push expected capture/timeout
// events derived from waveform interval lengths; a monitor pops and compares.
module tb_ef_icap32;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        start;
  logic [15:0] prescaler;
  logic [2:0]  cfg;
  logic [31:0] timeout;
  logic        cap_in;
  logic [31:0] cnt;
  logic [31:0] cap_period;
  logic [31:0] cap_high;
  logic        cap_valid;
  logic        timeout_flag;
  logic        busy;

  typedef struct {
    bit          isTimeout;
    logic [31:0] period;
    logic [31:0] high;
    longint      cyc;
  } sb_entry_t;

  sb_entry_t   sb[$];
  int          nChecks = 0;
  int          nFails  = 0;
  longint      cyc     = 0;
  logic [31:0] modelPeriod = 0;
  logic [31:0] modelHigh   = 0;

  ef_icap32 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .start       (start),
    .prescaler   (prescaler),
    .cfg         (cfg),
    .timeout     (timeout),
    .cap_in      (cap_in),
    .cnt         (cnt),
    .cap_period  (cap_period),
    .cap_high    (cap_high),
    .cap_valid   (cap_valid),
    .timeout_flag(timeout_flag),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic waitClks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushExp(input bit isTo, input logic [31:0] p, input logic [31:0] h, input longint cy);
    sb_entry_t e;
    e.isTimeout = isTo;
    e.period    = p;
    e.high      = h;
    e.cyc       = cy;
    sb.push_back(e);
  endtask

  // Disable, configure, re-enable and arm; leaves the DUT waiting for a start edge.
  task automatic applyStimulus(input logic [2:0] c, input int p, input int to);
    en = 1'b0; start = 1'b0; cap_in = 1'b0;
    waitClks(6);
    cfg = c; prescaler = 16'(p); timeout = 32'(to);
    en = 1'b1;
    waitClks(2);
    start = 1'b1;
    waitClks(1);
    start = 1'b0;
    waitClks(2);
  endtask

  // Mode 00: a capture is expected when an interval holds at most timeout+1
  // ticks, otherwise a timeout at tick timeout+1 and the next rise re-arms.
  task automatic periodSeq(input int p, input int to, input int n, input int firstLen,
                           input int loMul, input int hiMul);
    longint rTime;
    int     len;
    int     h;
    int     ticks;
    cap_in = 1'b1;
    rTime  = cyc;
    for (int i = 0; i < n; i++) begin
      len   = (i == 0 && firstLen > 0) ? firstLen : (p + 1) * int'($urandom_range(hiMul, loMul));
      ticks = len / (p + 1);
      if (to != 0 && ticks > to + 1) begin
        pushExp(1'b1, modelPeriod, modelHigh, (p == 0) ? rTime + 4 + to : -1);
      end else begin
        modelPeriod = 32'(ticks);
        pushExp(1'b0, modelPeriod, modelHigh, rTime + len + 3);
      end
      h = len / 2;
      waitClks(h);
      cap_in = 1'b0;
      waitClks(len - h);
      cap_in = 1'b1;
      rTime  = cyc;
    end
    waitClks(6);
  endtask

  // Mode 11 at prescaler 0: first period 30 high / 70 low, then random shapes.
  task automatic bothSeq(input int n);
    longint rTime;
    int     h;
    int     lo;
    cap_in = 1'b1;
    rTime  = cyc;
    for (int i = 0; i < n; i++) begin
      h  = (i == 0) ? 30 : int'($urandom_range(40, 5));
      lo = (i == 0) ? 70 : int'($urandom_range(80, 5));
      modelHigh   = 32'(h);
      modelPeriod = 32'(h + lo);
      pushExp(1'b0, modelPeriod, modelHigh, rTime + h + lo + 3);
      waitClks(h);
      cap_in = 1'b0;
      waitClks(lo);
      cap_in = 1'b1;
      rTime  = cyc;
    end
    waitClks(6);
  endtask

  // Monitor: every cap_valid/timeout_flag pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (cap_valid || timeout_flag)) begin
      if (sb.size() == 0) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected event: cap_valid=%0b timeout_flag=%0b, expected none (cycle %0d)",
                 cap_valid, timeout_flag, cyc);
      end else begin
        sb_entry_t e;
        e = sb.pop_front();
        checkOutput("event kind {cap_valid,timeout_flag}", 32'({cap_valid, timeout_flag}),
                    e.isTimeout ? 32'd1 : 32'd2);
        checkOutput("cap_period", cap_period, e.period);
        checkOutput("cap_high", cap_high, e.high);
        if (e.cyc >= 0) checkOutput("event cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1; en = 1'b0; start = 1'b0; cap_in = 1'b0;
    cfg = 3'b000; prescaler = 16'd0; timeout = 32'd0;
    #2 rst_n = 1'b0;
    waitClks(3);
    checkOutput("reset cnt", cnt, 32'd0);
    checkOutput("reset cap_period", cap_period, 32'd0);
    checkOutput("reset cap_high", cap_high, 32'd0);
    checkOutput("reset cap_valid", 32'(cap_valid), 32'd0);
    checkOutput("reset timeout_flag", 32'(timeout_flag), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    waitClks(2);

    $display("[TB] mode 11 continuous, prescaler 0");
    applyStimulus(3'b111, 0, 0);
    checkOutput("armed busy", 32'(busy), 32'd1);
    bothSeq(5);

    $display("[TB] mode 00 continuous, prescaler 3");
    applyStimulus(3'b100, 3, 0);
    periodSeq(3, 0, 4, 100, 10, 50);

    $display("[TB] mode 01 one-shot, prescaler 0");
    applyStimulus(3'b001, 0, 0);
    cap_in = 1'b1;
    modelPeriod = 32'd40;
    pushExp(1'b0, modelPeriod, modelHigh, cyc + 40 + 3);
    waitClks(40);
    cap_in = 1'b0;
    waitClks(6);
    checkOutput("one-shot busy after capture", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cap_in = 1'b1; waitClks(15);
      cap_in = 1'b0; waitClks(15);
    end
    checkOutput("one-shot cap_period held", cap_period, modelPeriod);

    $display("[TB] timeout 50, cap_in static after rise");
    applyStimulus(3'b000, 0, 50);
    periodSeq(0, 50, 1, 120, 1, 1);
    checkOutput("timeout one-shot busy", 32'(busy), 32'd0);
    checkOutput("timeout cnt cleared", cnt, 32'd0);

    $display("[TB] end edge coincident with timeout");
    applyStimulus(3'b000, 0, 50);
    periodSeq(0, 50, 1, 51, 1, 1);
    checkOutput("coincident one-shot busy", 32'(busy), 32'd0);

    $display("[TB] mode 00 continuous, random intervals around timeout 50");
    applyStimulus(3'b100, 0, 50);
    periodSeq(0, 50, 8, 0, 30, 80);

    $display("[TB] en dropped mid-measurement");
    applyStimulus(3'b100, 0, 0);
    cap_in = 1'b1;
    waitClks(20);
    checkOutput("measuring busy", 32'(busy), 32'd1);
    checkOutput("measuring cnt", cnt, 32'd17);
    en = 1'b0;
    waitClks(1);
    checkOutput("disabled busy", 32'(busy), 32'd0);
    checkOutput("disabled cnt", cnt, 32'd0);
    checkOutput("disabled cap_period held", cap_period, modelPeriod);
    checkOutput("disabled cap_high held", cap_high, modelHigh);
    cap_in = 1'b0; waitClks(10);
    cap_in = 1'b1; waitClks(10);

    waitClks(5);
    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
